// File: rtl/sdram_pkg.sv
// Shared SDRAM PHY types: pin-level command encoding and read-latency helper.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        MRS     = 4'b0000,
        REF     = 4'b0001,
        PRE     = 4'b0010,
        ACT     = 4'b0011,
        WRITE   = 4'b0100,
        READ    = 4'b0101,
        NOP     = 4'b0111,
        INHIBIT = 4'b1111
    } sdram_cmd_t;

    // Issue-to-rd_valid latency; returns 0 for an unsupported CAS latency or capture depth.
    function automatic int rd_lat(input int cas, input int cap);
        if ((cas == 2 || cas == 3) && cap >= 0 && cap <= 2) begin
            return 2 + cas + cap;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/sdram_phy_reg_if.sv
// Core-side bus between the SDRAM controller (master) and the pin PHY (slave).
interface sdram_phy_reg_if #(
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQM_W  = DQ_W / 8
);
    logic              cke_i;
    logic [3:0]        cmd_i;
    logic [ADDR_W-1:0] addr_i;
    logic [BA_W-1:0]   ba_i;
    logic [DQM_W-1:0]  dqm_i;
    logic              wr_en_i;
    logic [DQ_W-1:0]   wr_data_i;
    logic              rd_issue_i;
    logic              rd_valid_o;
    logic [DQ_W-1:0]   rd_data_o;
    logic              conflict_o;
    logic [7:0]        conflict_cnt_o;

    modport master (
        output cke_i, cmd_i, addr_i, ba_i, dqm_i, wr_en_i, wr_data_i, rd_issue_i,
        input  rd_valid_o, rd_data_o, conflict_o, conflict_cnt_o
    );

    modport slave (
        input  cke_i, cmd_i, addr_i, ba_i, dqm_i, wr_en_i, wr_data_i, rd_issue_i,
        output rd_valid_o, rd_data_o, conflict_o, conflict_cnt_o
    );
endinterface

// File: rtl/sdram_dq_iob.sv
// One DQ bit: output, output-enable and input-capture flops packed into the pad,
// plus the tristate driver (an IOBUF on the target device).
module sdram_dq_iob (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic oe,
    input  logic cap_en,
    output logic q,
    inout  wire  pad
);
    (* IOB = "TRUE" *) logic out_r;
    (* IOB = "TRUE" *) logic oe_r;
    (* IOB = "TRUE" *) logic cap_r;

    // Output data and enable flops; enable clears on reset so the pad comes up hi-Z.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= 1'b0;
            oe_r  <= 1'b0;
        end else begin
            out_r <= d;
            oe_r  <= oe;
        end
    end

    // Input capture; only loads on a read beat so the value holds between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_r <= 1'b0;
        end else if (cap_en) begin
            cap_r <= pad;
        end
    end

    assign pad = oe_r ? out_r : 1'bz;
    assign q   = cap_r;

endmodule

// File: rtl/sdram_phy_reg.sv
// Registered SDRAM pin PHY: command/address flops, per-bit DQ IOBs, a CAS-aligned
// read-valid pipeline and a turnaround check that drops writes colliding with read data.
module sdram_phy_reg
    import sdram_pkg::*;
#(
    parameter int DQ_W    = 16,
    parameter int ADDR_W  = 13,
    parameter int BA_W    = 2,
    parameter int DQM_W   = DQ_W / 8,
    parameter int CAS_LAT = 2,
    parameter int CAP_DLY = 0
) (
    input  logic              clk,
    input  logic              rst,
    sdram_phy_reg_if.slave    core,
    output logic              clk_sdram,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [ADDR_W-1:0] sdram_a,
    output logic [BA_W-1:0]   sdram_bs,
    output logic [DQM_W-1:0]  sdram_dqm,
    inout  wire  [DQ_W-1:0]   sdram_dq
);
    localparam int RD_LAT = rd_lat(CAS_LAT, CAP_DLY);

    if (RD_LAT == 0) begin : g_bad_cfg
        $error("sdram_phy_reg: CAS_LAT must be 2 or 3 and CAP_DLY 0..2");
    end

    (* IOB = "TRUE" *) logic              cke_r;
    (* IOB = "TRUE" *) sdram_cmd_t        cmd_r;
    (* IOB = "TRUE" *) logic [ADDR_W-1:0] a_r;
    (* IOB = "TRUE" *) logic [BA_W-1:0]   bs_r;
    (* IOB = "TRUE" *) logic [DQM_W-1:0]  dqm_r;

    // pend_r[k] set means a read was issued k cycles ago
    logic [RD_LAT:1] pend_r;
    logic            conflict_s;
    logic            oe_s;
    logic            conflict_r;
    logic [7:0]      cnt_r;
    logic [DQ_W-1:0] cap_s;
    logic [DQ_W-1:0] rd_data_s;

    // Turnaround window covers the read-data bus slot plus one cycle either side.
    always_comb begin
        conflict_s = core.wr_en_i &&
                     (core.rd_issue_i || (|pend_r[CAS_LAT+1:CAS_LAT-1]));
        oe_s       = core.wr_en_i && !conflict_s;
    end

    // Command and address pin registers; reset presents INHIBIT with CKE low and all bytes masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            cke_r <= 1'b0;
            cmd_r <= INHIBIT;
            a_r   <= {ADDR_W{1'b0}};
            bs_r  <= {BA_W{1'b0}};
            dqm_r <= {DQM_W{1'b1}};
        end else begin
            cke_r <= core.cke_i;
            cmd_r <= sdram_cmd_t'(core.cmd_i);
            a_r   <= core.addr_i;
            bs_r  <= core.ba_i;
            dqm_r <= core.dqm_i;
        end
    end

    // Read-pending shift register, conflict pulse and saturating conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r     <= {RD_LAT{1'b0}};
            conflict_r <= 1'b0;
            cnt_r      <= 8'd0;
        end else begin
            pend_r     <= {pend_r[RD_LAT-1:1], core.rd_issue_i};
            conflict_r <= conflict_s;
            if (conflict_s && cnt_r != 8'hFF) begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < DQ_W; g++) begin : g_dq
        sdram_dq_iob u_iob (
            .clk    (clk),
            .rst    (rst),
            .d      (core.wr_data_i[g]),
            .oe     (oe_s),
            .cap_en (pend_r[CAS_LAT+1]),
            .q      (cap_s[g]),
            .pad    (sdram_dq[g])
        );
    end

    if (CAP_DLY == 0) begin : g_no_dly
        assign rd_data_s = cap_s;
    end else begin : g_dly
        logic [DQ_W-1:0] dly_r [1:CAP_DLY];

        // Board-delay stages; each loads only when its beat arrives so the tail holds data.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 1; j <= CAP_DLY; j++) begin
                    dly_r[j] <= {DQ_W{1'b0}};
                end
            end else begin
                if (pend_r[CAS_LAT+2]) begin
                    dly_r[1] <= cap_s;
                end
                for (int j = 2; j <= CAP_DLY; j++) begin
                    if (pend_r[CAS_LAT+1+j]) begin
                        dly_r[j] <= dly_r[j-1];
                    end
                end
            end
        end

        assign rd_data_s = dly_r[CAP_DLY];
    end

    // Simulation model of the vendor ODDR (D0=0, D1=1), which forwards the inverted clock.
    assign clk_sdram = ~clk;

    assign sdram_cke           = cke_r;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_r;
    assign sdram_a             = a_r;
    assign sdram_bs            = bs_r;
    assign sdram_dqm           = dqm_r;
    assign core.rd_valid_o     = pend_r[RD_LAT];
    assign core.rd_data_o      = rd_data_s;
    assign core.conflict_o     = conflict_r;
    assign core.conflict_cnt_o = cnt_r;

endmodule

// File: tb/tb_sdram_phy_reg.sv
// Directed bench for sdram_phy_reg: one PHY at CAS latency 2 and one at 3, sharing stimulus,
// each with a behavioural device that returns read data at issue+1+CAS.
module tb_sdram_phy_reg;
    import sdram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] rd_word = 16'h0000;

    sdram_phy_reg_if #(.DQ_W(16), .ADDR_W(13), .BA_W(2)) c2 ();
    sdram_phy_reg_if #(.DQ_W(16), .ADDR_W(13), .BA_W(2)) c3 ();

    assign c3.cke_i      = c2.cke_i;
    assign c3.cmd_i      = c2.cmd_i;
    assign c3.addr_i     = c2.addr_i;
    assign c3.ba_i       = c2.ba_i;
    assign c3.dqm_i      = c2.dqm_i;
    assign c3.wr_en_i    = c2.wr_en_i;
    assign c3.wr_data_i  = c2.wr_data_i;
    assign c3.rd_issue_i = c2.rd_issue_i;

    wire        clk2, clk3, cke2, cke3;
    wire [3:0]  cmd2, cmd3;
    wire [12:0] a2, a3;
    wire [1:0]  bs2, bs3, dqm2, dqm3;
    wire [15:0] dq2, dq3;

    sdram_phy_reg #(.CAS_LAT(2), .CAP_DLY(0)) dut2 (
        .clk(clk), .rst(rst), .core(c2), .clk_sdram(clk2), .sdram_cke(cke2),
        .sdram_cs_n(cmd2[3]), .sdram_ras_n(cmd2[2]), .sdram_cas_n(cmd2[1]), .sdram_we_n(cmd2[0]),
        .sdram_a(a2), .sdram_bs(bs2), .sdram_dqm(dqm2), .sdram_dq(dq2)
    );

    sdram_phy_reg #(.CAS_LAT(3), .CAP_DLY(0)) dut3 (
        .clk(clk), .rst(rst), .core(c3), .clk_sdram(clk3), .sdram_cke(cke3),
        .sdram_cs_n(cmd3[3]), .sdram_ras_n(cmd3[2]), .sdram_cas_n(cmd3[1]), .sdram_we_n(cmd3[0]),
        .sdram_a(a3), .sdram_bs(bs3), .sdram_dqm(dqm3), .sdram_dq(dq3)
    );

    // Device model: dv[k] set during the cycle k+1 after an issue; data rides alongside.
    logic [7:0]  dv = 8'd0;
    logic [15:0] dd [0:7];
    always @(posedge clk) begin
        dv    <= {dv[6:0], c2.rd_issue_i};
        dd[0] <= rd_word;
        for (int k = 1; k < 8; k++) dd[k] <= dd[k-1];
    end
    assign dq2 = dv[2] ? dd[2] : 16'hzzzz;
    assign dq3 = dv[3] ? dd[3] : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c2.cke_i      = 1'b1;
        c2.cmd_i      = NOP;
        c2.dqm_i      = 2'b00;
        c2.wr_en_i    = 1'b0;
        c2.rd_issue_i = 1'b0;
    endtask

    // rd at t, write at t+2 lands on the read-data slot for CAS 2
    task automatic conflict_seq(input logic [15:0] rdv);
        c2.rd_issue_i = 1'b1; c2.cmd_i = READ; rd_word = rdv;
        step(); idle();
        step(); c2.wr_en_i = 1'b1; c2.wr_data_i = 16'h5A5A; c2.cmd_i = WRITE;
        step(); idle();
    endtask

    initial begin
        idle();
        c2.addr_i = 13'd0; c2.ba_i = 2'd0; c2.wr_data_i = 16'h0000;

        // Reset with scrambled core inputs and a write request held high
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c2.cke_i = 1'($urandom); c2.cmd_i = 4'($urandom); c2.addr_i = 13'($urandom);
            c2.ba_i = 2'($urandom); c2.dqm_i = 2'($urandom);
            c2.wr_en_i = 1'b1; c2.wr_data_i = 16'hFFFF;
            step();
        end
        chk("rst_cke", cke2, 1'b0);
        chk("rst_cmd", cmd2, INHIBIT);
        chk("rst_cmd3", cmd3, INHIBIT);
        chk("rst_dqm", dqm2, 2'b11);
        chk("rst_a", a2, 13'd0);
        chk("rst_bs", bs2, 2'd0);
        chk("rst_dq_driven", dq2 === 16'hFFFF, 1'b0);
        chk("rst_rd_valid", c2.rd_valid_o, 1'b0);
        chk("rst_rd_data", c2.rd_data_o, 16'h0000);
        chk("rst_conflict", c2.conflict_o, 1'b0);
        chk("rst_cnt", c2.conflict_cnt_o, 8'd0);
        chk("clk_fwd", clk2, 1'b0);

        rst = 1'b0; idle(); c2.wr_data_i = 16'h0000;
        step();

        // Command path: one register stage
        c2.cke_i = 1'b1; c2.cmd_i = ACT; c2.addr_i = 13'h1ABC; c2.ba_i = 2'd2; c2.dqm_i = 2'b01;
        step();
        chk("cmd_cke", cke2, 1'b1);
        chk("cmd_code", cmd2, ACT);
        chk("cmd_a", a2, 13'h1ABC);
        chk("cmd_bs", bs2, 2'd2);
        chk("cmd_dqm", dqm2, 2'b01);
        idle(); step();

        // Single write: driven for exactly one cycle
        c2.wr_en_i = 1'b1; c2.wr_data_i = 16'hA5C3; c2.cmd_i = WRITE;
        step(); idle();
        chk("wr_drive", dq2, 16'hA5C3);
        chk("wr_drive3", dq3, 16'hA5C3);
        chk("wr_no_conflict", c2.conflict_o, 1'b0);
        step();
        chk("wr_release", dq2 === 16'hA5C3, 1'b0);

        // Back-to-back writes
        c2.wr_en_i = 1'b1; c2.wr_data_i = 16'h1111;
        step(); c2.wr_data_i = 16'h2222;
        chk("b2b_beat0", dq2, 16'h1111);
        step(); idle();
        chk("b2b_beat1", dq2, 16'h2222);
        step();
        chk("b2b_release", dq2 === 16'h2222, 1'b0);
        step();

        // Single read: valid at issue+4 (CAS 2) and issue+5 (CAS 3), one cycle, data held after
        c2.rd_issue_i = 1'b1; c2.cmd_i = READ; rd_word = 16'h1234;
        step(); idle();
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("rd_valid2_k%0d", k), c2.rd_valid_o, k == 4);
            chk($sformatf("rd_valid3_k%0d", k), c3.rd_valid_o, k == 5);
            if (k >= 4) chk($sformatf("rd_data2_k%0d", k), c2.rd_data_o, 16'h1234);
            if (k >= 5) chk($sformatf("rd_data3_k%0d", k), c3.rd_data_o, 16'h1234);
            step();
        end

        // Burst of four beats, data 1..4, no gaps
        for (int i = 0; i < 4; i++) begin
            c2.rd_issue_i = 1'b1; c2.cmd_i = READ; rd_word = 16'(i + 1);
            step();
        end
        idle();
        for (int k = 4; k <= 9; k++) begin
            chk($sformatf("burst_v2_k%0d", k), c2.rd_valid_o, (k >= 4) && (k <= 7));
            chk($sformatf("burst_v3_k%0d", k), c3.rd_valid_o, (k >= 5) && (k <= 8));
            if (k <= 7) chk($sformatf("burst_d2_k%0d", k), c2.rd_data_o, 16'(k - 3));
            if (k >= 5 && k <= 8) chk($sformatf("burst_d3_k%0d", k), c3.rd_data_o, 16'(k - 4));
            step();
        end

        // Write four cycles after a read sits outside the CAS 2 window
        c2.rd_issue_i = 1'b1; c2.cmd_i = READ; rd_word = 16'h7777;
        step(); idle(); step(); step(); step();
        c2.wr_en_i = 1'b1; c2.wr_data_i = 16'hC3C3;
        step(); idle();
        chk("edge_no_conflict", c2.conflict_o, 1'b0);
        chk("edge_drive", dq2, 16'hC3C3);
        chk("edge_cnt", c2.conflict_cnt_o, 8'd0);
        step(); step(); step();

        // Colliding write: dropped, flagged, command still passes, read returns
        conflict_seq(16'h1234);
        chk("cf_pulse", c2.conflict_o, 1'b1);
        chk("cf_bus", dq2, 16'h1234);
        chk("cf_cnt1", c2.conflict_cnt_o, 8'd1);
        chk("cf_cmd_pass", cmd2, WRITE);
        step();
        chk("cf_pulse_end", c2.conflict_o, 1'b0);
        chk("cf_rd_valid", c2.rd_valid_o, 1'b1);
        chk("cf_rd_data", c2.rd_data_o, 16'h1234);
        step(); step();

        // Write in the same cycle as a read issue
        c2.rd_issue_i = 1'b1; c2.cmd_i = READ; c2.wr_en_i = 1'b1; c2.wr_data_i = 16'h0F0F;
        step(); idle();
        chk("same_cycle_pulse", c2.conflict_o, 1'b1);
        chk("same_cycle_cnt2", c2.conflict_cnt_o, 8'd2);
        step(); step(); step(); step();

        // 298 more conflicts: 300 in total, counter stops at 255
        for (int i = 0; i < 298; i++) begin
            conflict_seq(16'(i));
            step();
        end
        chk("cnt_saturate", c2.conflict_cnt_o, 8'd255);
        step(); step(); step();

        // Reset one cycle after an issue: that read never reports valid
        c2.rd_issue_i = 1'b1; c2.cmd_i = READ; rd_word = 16'hBEEF;
        step(); idle(); rst = 1'b1;
        step(); rst = 1'b0;
        chk("midrst_cnt", c2.conflict_cnt_o, 8'd0);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("midrst_v2_k%0d", k), c2.rd_valid_o, 1'b0);
            chk($sformatf("midrst_v3_k%0d", k), c3.rd_valid_o, 1'b0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
